// File: rtl/doodle_pkg.sv
// Shared screen geometry, keycodes and state encoding for the doodle logic.
package doodle_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_SPACE = 8'h2C;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AIR  = 2'd1,
        DEAD = 2'd2
    } doodle_state_t;

endpackage

// File: rtl/doodle_motion_frame_tick.sv
// Brings the asynchronous frame pulse into the Clk domain and turns each
// rising edge into a single-cycle tick. Also intended for platform scrolling.
module frame_tick (
    input  logic Clk,
    input  logic frame_clk,
    output logic tick
);

    logic sync0;
    logic sync1;
    logic delay;

    // Two-flop synchroniser followed by one delay flop for edge detection.
    // Left unreset on purpose: a reset here would clear the delay flop and
    // fake a rising edge if frame_clk happened to be high on release.
    always_ff @(posedge Clk) begin
        sync0 <= frame_clk;
        sync1 <= sync0;
        delay <= sync1;
    end

    assign tick = sync1 & ~delay;

endmodule

// File: rtl/doodle_motion.sv
// Doodle sprite position and physics: keyboard-driven horizontal motion,
// gravity auto-bounce on the bottom platform, wrap, ceiling clamp, fall-off.
module doodle_motion
    import doodle_pkg::*;
#(
    parameter int START_X  = 272,
    parameter int SIZE_X   = 8,
    parameter int SIZE_Y   = 16,
    parameter int PLAT_XL  = 240,
    parameter int PLAT_XR  = 320,
    parameter int PLAT_Y   = 470,
    parameter int H_SPEED  = 3,
    parameter int JUMP_V   = 12,
    parameter int GRAVITY  = 1,
    parameter int MAX_FALL = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    output logic [9:0] DoodleX,
    output logic [9:0] DoodleY,
    output logic [9:0] DoodleSizeX,
    output logic [9:0] DoodleSizeY,
    output logic       facing_left,
    output logic       game_over,
    output logic [1:0] state_o
);

    localparam logic signed [10:0] START_X_S  = 11'(START_X);
    localparam logic signed [10:0] SIZE_X_S   = 11'(SIZE_X);
    localparam logic signed [10:0] SIZE_Y_S   = 11'(SIZE_Y);
    localparam logic signed [10:0] PLAT_XL_S  = 11'(PLAT_XL);
    localparam logic signed [10:0] PLAT_XR_S  = 11'(PLAT_XR);
    localparam logic signed [10:0] PLAT_Y_S   = 11'(PLAT_Y);
    localparam logic signed [10:0] H_SPEED_S  = 11'(H_SPEED);
    localparam logic signed [10:0] JUMP_V_S   = 11'(JUMP_V);
    localparam logic signed [10:0] GRAVITY_S  = 11'(GRAVITY);
    localparam logic signed [10:0] MAX_FALL_S = 11'(MAX_FALL);
    localparam logic signed [10:0] SCR_W_S    = 11'(SCREEN_W);
    localparam logic signed [10:0] SCR_H_S    = 11'(SCREEN_H);
    localparam logic signed [10:0] REST_Y_S   = PLAT_Y_S - SIZE_Y_S;

    // Clamp downward speed so a long fall cannot tunnel through the platform.
    function automatic logic signed [10:0] sat_fall(input logic signed [10:0] v);
        return (v > MAX_FALL_S) ? MAX_FALL_S : v;
    endfunction

    // Fold a horizontally stepped X back into 0..SCREEN_W-1.
    function automatic logic signed [10:0] wrap_x(input logic signed [10:0] v);
        if (v < 11'sd0)
            return v + SCR_W_S;
        else if (v >= SCR_W_S)
            return v - SCR_W_S;
        else
            return v;
    endfunction

    logic tick;

    frame_tick u_frame_tick (
        .Clk       (Clk),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

    doodle_state_t     state, state_n;
    logic signed [10:0] x, x_n;
    logic signed [10:0] y, y_n;
    logic signed [10:0] vy, vy_n;
    logic              facing, facing_n;

    logic signed [10:0] x_mv;
    logic              facing_mv;
    logic signed [10:0] vy_g;
    logic signed [10:0] y_g;
    logic              landing;

    // Per-frame physics: horizontal step, gravity, then landing / fall-off /
    // ceiling / free flight in that priority order.
    always_comb begin
        state_n   = state;
        x_n       = x;
        y_n       = y;
        vy_n      = vy;
        facing_n  = facing;

        x_mv      = x;
        facing_mv = facing;
        if (keycode == KEY_A) begin
            x_mv      = wrap_x(x - H_SPEED_S);
            facing_mv = 1'b1;
        end else if (keycode == KEY_D) begin
            x_mv      = wrap_x(x + H_SPEED_S);
            facing_mv = 1'b0;
        end

        vy_g = sat_fall(vy + GRAVITY_S);
        y_g  = y + vy_g;

        // Overlap uses the pre-step X so landing matches what was on screen.
        landing = (vy_g > 11'sd0) &&
                  (y + SIZE_Y_S <= PLAT_Y_S) &&
                  (y_g + SIZE_Y_S >= PLAT_Y_S) &&
                  (x + SIZE_X_S > PLAT_XL_S) &&
                  (x < PLAT_XR_S);

        unique case (state)
            IDLE: begin
                x_n      = x_mv;
                facing_n = facing_mv;
                if (keycode == KEY_SPACE) begin
                    state_n = AIR;
                    vy_n    = -JUMP_V_S;
                    y_n     = y - JUMP_V_S;
                end
            end
            AIR: begin
                if (landing) begin
                    x_n      = x_mv;
                    facing_n = facing_mv;
                    y_n      = REST_Y_S;
                    vy_n     = -JUMP_V_S;
                end else if (y_g >= SCR_H_S) begin
                    state_n = DEAD;
                end else if (y_g < 11'sd0) begin
                    x_n      = x_mv;
                    facing_n = facing_mv;
                    y_n      = 11'sd0;
                    vy_n     = 11'sd0;
                end else begin
                    x_n      = x_mv;
                    facing_n = facing_mv;
                    y_n      = y_g;
                    vy_n     = vy_g;
                end
            end
            default: begin
                state_n = state;
            end
        endcase
    end

    // State registers: Reset wins over a coincident tick; otherwise commit
    // the frame update only on the tick cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= IDLE;
            x      <= START_X_S;
            y      <= REST_Y_S;
            vy     <= 11'sd0;
            facing <= 1'b0;
        end else if (tick) begin
            state  <= state_n;
            x      <= x_n;
            y      <= y_n;
            vy     <= vy_n;
            facing <= facing_n;
        end
    end

    assign DoodleX     = x[9:0];
    assign DoodleY     = y[9:0];
    assign DoodleSizeX = 10'(SIZE_X);
    assign DoodleSizeY = 10'(SIZE_Y);
    assign facing_left = facing;
    assign game_over   = (state == DEAD);
    assign state_o     = state;

endmodule

// File: tb/tb_doodle_motion.sv
// Directed bench for doodle_motion: table of bounce vectors plus hand-written
// sequences for reset, wrap, fall-off and tick isolation.
module tb_doodle_motion;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic [9:0] DoodleX, DoodleY, DoodleSizeX, DoodleSizeY;
    logic       facing_left, game_over;
    logic [1:0] state_o;

    int n_checks = 0;
    int n_fail   = 0;

    doodle_motion dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_clk   (frame_clk),
        .keycode     (keycode),
        .DoodleX     (DoodleX),
        .DoodleY     (DoodleY),
        .DoodleSizeX (DoodleSizeX),
        .DoodleSizeY (DoodleSizeY),
        .facing_left (facing_left),
        .game_over   (game_over),
        .state_o     (state_o)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0] key;
        int         x;
        int         y;
        int         st;
    } vec_t;

    vec_t vecs[28];
    int   ys[28] = '{442, 431, 421, 412, 404, 397, 391, 386, 382, 379, 377, 376, 376, 377,
                     379, 382, 386, 391, 397, 404, 412, 420, 428, 436, 444, 452, 454, 443};

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // One frame pulse; outputs are settled when this returns.
    task automatic frame(input logic [7:0] key);
        keycode   = key;
        frame_clk = 1'b1;
        cycles(4);
        frame_clk = 1'b0;
        cycles(3);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        cycles(2);
        Reset = 1'b0;
        cycles(1);
    endtask

    int min_y;

    initial begin
        // Reset held with frame_clk toggling and D pressed: nothing moves.
        Reset   = 1'b1;
        keycode = 8'h07;
        cycles(1);
        for (int i = 0; i < 4; i++) begin
            frame_clk = ~frame_clk;
            cycles(2);
        end
        frame_clk = 1'b0;
        chk("reset_hold_x", DoodleX, 272);
        cycles(4);
        Reset = 1'b0;
        cycles(3);
        chk("reset_x", DoodleX, 272);
        chk("reset_y", DoodleY, 454);
        chk("reset_state", state_o, 0);
        chk("reset_game_over", game_over, 0);
        chk("reset_facing", facing_left, 0);
        chk("size_x", DoodleSizeX, 8);
        chk("size_y", DoodleSizeY, 16);

        // Launch and full bounce cycle back to the platform, keys released.
        vecs[0] = '{8'h2C, 272, ys[0], 1};
        for (int i = 1; i < 28; i++) vecs[i] = '{8'h00, 272, ys[i], 1};
        min_y = 1000;
        for (int i = 0; i < 28; i++) begin
            frame(vecs[i].key);
            chk($sformatf("bounce_y[%0d]", i), DoodleY, vecs[i].y);
            chk($sformatf("bounce_x[%0d]", i), DoodleX, vecs[i].x);
            chk($sformatf("bounce_st[%0d]", i), state_o, vecs[i].st);
            if (DoodleY < min_y) min_y = DoodleY;
        end
        chk("apex_not_below_376", (min_y >= 376) ? 1 : 0, 1);

        // Wrap left from reset: 90 steps of 3 reach 2, the next gives 639.
        do_reset();
        frame(8'h04);
        chk("wrap_a_first_x", DoodleX, 269);
        chk("wrap_a_facing", facing_left, 1);
        for (int i = 1; i < 90; i++) frame(8'h04);
        chk("wrap_a_x2", DoodleX, 2);
        chk("wrap_a_y", DoodleY, 454);
        chk("wrap_a_state", state_o, 0);
        frame(8'h04);
        chk("wrap_a_x639", DoodleX, 639);
        chk("wrap_a_facing_end", facing_left, 1);

        // Wrap right: 122 steps reach 638, the next gives 1.
        do_reset();
        for (int i = 0; i < 122; i++) frame(8'h07);
        chk("wrap_d_x638", DoodleX, 638);
        frame(8'h07);
        chk("wrap_d_x1", DoodleX, 1);
        chk("wrap_d_facing", facing_left, 0);
        frame(8'h11);
        chk("other_key_x", DoodleX, 1);

        // Fall-off: drift right past the platform edge while in the air.
        do_reset();
        frame(8'h2C);
        for (int i = 1; i <= 25; i++) frame(8'h07);
        chk("fall_t25_x", DoodleX, 347);
        chk("fall_t25_y", DoodleY, 452);
        frame(8'h07);
        chk("fall_t26_y_no_land", DoodleY, 460);
        chk("fall_t26_state", state_o, 1);
        frame(8'h07);
        frame(8'h07);
        chk("fall_t28_y", DoodleY, 476);
        chk("fall_t28_x", DoodleX, 356);
        chk("fall_t28_state", state_o, 1);
        frame(8'h07);
        chk("dead_state", state_o, 2);
        chk("dead_game_over", game_over, 1);
        chk("dead_x_frozen", DoodleX, 356);
        chk("dead_y_frozen", DoodleY, 476);
        frame(8'h04);
        frame(8'h2C);
        frame(8'h07);
        chk("dead_stays_x", DoodleX, 356);
        chk("dead_stays_y", DoodleY, 476);
        chk("dead_stays_state", state_o, 2);
        chk("dead_stays_facing", facing_left, 0);
        do_reset();
        chk("dead_reset_state", state_o, 0);
        chk("dead_reset_game_over", game_over, 0);
        chk("dead_reset_x", DoodleX, 272);
        chk("dead_reset_y", DoodleY, 454);

        // frame_clk held high for 100 cycles: one update only, and a later
        // keycode change while it stays high is ignored.
        keycode   = 8'h07;
        frame_clk = 1'b1;
        cycles(20);
        keycode = 8'h04;
        cycles(80);
        frame_clk = 1'b0;
        cycles(3);
        chk("hold_high_x", DoodleX, 275);
        chk("hold_high_facing", facing_left, 0);

        // Reset coincident with the tick cycle: reset values, no update.
        keycode   = 8'h07;
        frame_clk = 1'b1;
        Reset     = 1'b1;
        cycles(3);
        Reset = 1'b0;
        cycles(3);
        frame_clk = 1'b0;
        cycles(3);
        chk("reset_tick_x", DoodleX, 272);
        chk("reset_tick_y", DoodleY, 454);
        chk("reset_tick_state", state_o, 0);

        // Mid-flight reset returns to the platform.
        frame(8'h2C);
        frame(8'h00);
        chk("midair_y", DoodleY, 431);
        do_reset();
        chk("midair_reset_y", DoodleY, 454);
        chk("midair_reset_state", state_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
